systolic_mac_array: RTL

//   Parametrised N x N output-stationary systolic array computing C = A*B over a stream of K beats.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_mac_array_if.sv | 30 +++
 rtl/systolic_pe.sv | 74 +++++++
 rtl/systolic_mac_array.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic MAC array.
package systolic_pkg;

  typedef enum logic [1:0] {
    MODE_OR   = 2'b00,
    MODE_XOR  = 2'b01,
    MODE_WRAP = 2'b10,
    MODE_SAT  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Bubble cycles needed for the last accepted beat to reach the far corner PE.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// Operand-in / result-out handshake bundle of the systolic MAC array.
interface systolic_mac_array_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 2,
  parameter int unsigned ACC_W = 8
);
  localparam int unsigned ROW_W = (N > 1) ? $clog2(N) : 1;

  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     a_in;
  logic [N*W-1:0]     b_in;
  logic               drain_req;
  logic               out_valid;
  logic               out_ready;
  logic [N*ACC_W-1:0] out_data;
  logic [ROW_W-1:0]   out_row;
  logic               busy;

  modport master (
    output mode, in_valid, a_in, b_in, drain_req, out_ready,
    input  in_ready, out_valid, out_data, out_row, busy
  );

  modport slave (
    input  mode, in_valid, a_in, b_in, drain_req, out_ready,
    output in_ready, out_valid, out_data, out_row, busy
  );
endinterface

// File: rtl/systolic_pe.sv
// One processing element: registered operand/valid pass-through plus a mode-selected accumulator.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  mode_e            mode,
  input  logic [W-1:0]     a_i,
  input  logic             va_i,
  input  logic [W-1:0]     b_i,
  input  logic             vb_i,
  output logic [W-1:0]     a_o,
  output logic             va_o,
  output logic [W-1:0]     b_o,
  output logic             vb_o,
  output logic [ACC_W-1:0] acc_o
);

  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             va_q, va_d, vb_q, vb_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [W-1:0]     and_c;
  logic [2*W-1:0]   prod_c;
  logic [ACC_W:0]   sum_c;

  always_comb begin
    a_d    = a_i;
    va_d   = va_i;
    b_d    = b_i;
    vb_d   = vb_i;
    and_c  = a_i & b_i;
    prod_c = (2*W)'(a_i) * (2*W)'(b_i);
    // Extra carry bit lets saturation detect overflow without wrapping.
    sum_c  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_c);
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (va_i && vb_i) begin
      case (mode)
        MODE_OR:   acc_d = ACC_W'(acc_q[W-1:0] | and_c);
        MODE_XOR:  acc_d = ACC_W'(acc_q[W-1:0] ^ and_c);
        MODE_WRAP: acc_d = sum_c[ACC_W-1:0];
        default:   acc_d = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      va_q  <= 1'b0;
      b_q   <= '0;
      vb_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      va_q  <= va_d;
      b_q   <= b_d;
      vb_q  <= vb_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign va_o  = va_q;
  assign b_o   = b_q;
  assign vb_o  = vb_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// N x N output-stationary systolic array: input skew lines, mode latch, accumulate/flush/drain
// sequencer and registered result-row output.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 2,
  parameter int unsigned ACC_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  systolic_mac_array_if.slave bus
);

  localparam int unsigned ROW_W     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FLUSH_LEN = flush_len(N);
  localparam int unsigned CNT_W     = $clog2(FLUSH_LEN + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               out_valid_q, out_valid_d;
  logic [N*ACC_W-1:0] out_data_q, out_data_d;
  mode_e              mode_q, mode_d;
  logic               lat_q, lat_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic               accept_c;
  logic               clr_c;
  mode_e              eff_mode_c;
  logic [ROW_W-1:0]   row_sel_c;
  logic [N*ACC_W-1:0] row_data_c;
  logic               unused_edge_c;

  // Horizontal (A) and vertical (B) operand/valid nets; index N is the array edge.
  logic [W-1:0]     a_h  [N][N+1];
  logic             va_h [N][N+1];
  logic [W-1:0]     b_v  [N+1][N];
  logic             vb_v [N+1][N];
  logic [ACC_W-1:0] acc_w [N][N];

  assign accept_c   = bus.in_valid & in_ready_q;
  // The first beat of a job updates PE(0,0) on the same edge that latches its mode.
  assign eff_mode_c = lat_q ? mode_q : mode_e'(bus.mode);

  for (genvar l = 0; l < N; l++) begin : g_skew
    if (l == 0) begin : g_direct
      assign a_h[0][0]  = bus.a_in[W-1:0];
      assign va_h[0][0] = accept_c;
      assign b_v[0][0]  = bus.b_in[W-1:0];
      assign vb_v[0][0] = accept_c;
    end else begin : g_delay
      logic [W:0] a_sk_q [l];
      logic [W:0] a_sk_d [l];
      logic [W:0] b_sk_q [l];
      logic [W:0] b_sk_d [l];

      always_comb begin
        a_sk_d[0] = {accept_c, bus.a_in[l*W +: W]};
        b_sk_d[0] = {accept_c, bus.b_in[l*W +: W]};
        for (int k = 1; k < l; k++) begin
          a_sk_d[k] = a_sk_q[k-1];
          b_sk_d[k] = b_sk_q[k-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sk_q <= '{default: '0};
          b_sk_q <= '{default: '0};
        end else begin
          a_sk_q <= a_sk_d;
          b_sk_q <= b_sk_d;
        end
      end

      assign a_h[l][0]  = a_sk_q[l-1][W-1:0];
      assign va_h[l][0] = a_sk_q[l-1][W];
      assign b_v[0][l]  = b_sk_q[l-1][W-1:0];
      assign vb_v[0][l] = b_sk_q[l-1][W];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_c),
        .mode  (eff_mode_c),
        .a_i   (a_h[i][j]),
        .va_i  (va_h[i][j]),
        .b_i   (b_v[i][j]),
        .vb_i  (vb_v[i][j]),
        .a_o   (a_h[i][j+1]),
        .va_o  (va_h[i][j+1]),
        .b_o   (b_v[i+1][j]),
        .vb_o  (vb_v[i+1][j]),
        .acc_o (acc_w[i][j])
      );
    end
  end

  // Operands leaving the far edge of the array carry no further meaning.
  always_comb begin
    unused_edge_c = 1'b0;
    for (int l = 0; l < N; l++) begin
      unused_edge_c = unused_edge_c ^ (^a_h[l][N]) ^ va_h[l][N] ^ (^b_v[N][l]) ^ vb_v[N][l];
    end
  end

  // Row to load: the current row on entry to DRAIN, the next row after a handshake.
  always_comb begin
    row_sel_c = out_valid_q ? ROW_W'(row_q + ROW_W'(1)) : row_q;
    for (int j = 0; j < N; j++) begin
      row_data_c[j*ACC_W +: ACC_W] = acc_w[row_sel_c][j];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mode_d      = mode_q;
    lat_d       = lat_q;
    clr_c       = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        if (accept_c && !lat_q) begin
          mode_d = mode_e'(bus.mode);
          lat_d  = 1'b1;
        end
        if (bus.drain_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
          state_d = ST_DRAIN;
          row_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = row_data_c;
        end else if (bus.out_ready) begin
          if (row_q == ROW_W'(N - 1)) begin
            clr_c       = 1'b1;
            state_d     = ST_ACCUM;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            row_d       = '0;
            lat_d       = 1'b0;
          end else begin
            row_d      = ROW_W'(row_q + ROW_W'(1));
            out_data_d = row_data_c;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    in_ready_d = (state_d == ST_ACCUM);
    busy_d     = (state_d != ST_ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mode_q      <= MODE_OR;
      lat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mode_q      <= mode_d;
      lat_q       <= lat_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = row_q;
  assign bus.busy      = busy_q;

endmodule
